bin2bcd_converter: RTL and testbench

BIN2BCD_CONVERTER -- requirements
Module: bin2bcd_converter

---
 rtl/bin2bcd_converter.sv | 127 ++++++++++++
 tb/tb_bin2bcd_converter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_converter.sv
// 14-bit binary to 4-digit packed BCD converter (double dabble, one bit per cycle).
// Define BIN2BCD_SATURATE_EN to clamp bcd_out to 16'h9999 on overflow.
module bin2bcd_converter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [13:0] bin_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] bcd_out,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [1:0]  hi_q, hi_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] out_q, out_d;
    logic        ovf_q, ovf_d;

    logic [15:0] adj;
    logic [1:0]  hi_nx;
    logic [15:0] bcd_nx;
    logic        ovf_nx;
    logic [15:0] res_nx;

    function automatic logic [3:0] dabble(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    // One double-dabble step on the current scratch and the final-result view of it
    always_comb begin
        adj = '0;
        for (int i = 0; i < 4; i++) begin
            adj[4*i +: 4] = dabble(bcd_q[4*i +: 4]);
        end
        hi_nx  = {hi_q[0], adj[15]};
        bcd_nx = {adj[14:0], bin_q[13]};
        // hi_q[1] can only hold a carry that was already shifted past the
        // ten-thousands digit; folding it in keeps the flag sticky regardless.
        ovf_nx = (|hi_nx) | hi_q[1];
`ifdef BIN2BCD_SATURATE_EN
        res_nx = ovf_nx ? 16'h9999 : bcd_nx;
`else
        res_nx = bcd_nx;
`endif
    end

    // Next-state and datapath control for IDLE -> SHIFT x14 -> DONE
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    hi_d    = '0;
                    cnt_d   = 4'd13;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d = {bin_q[12:0], 1'b0};
                bcd_d = bcd_nx;
                hi_d  = hi_nx;
                if (cnt_q == 4'd0) begin
                    // Last step: latch the finished result straight into the
                    // output registers so DONE presents it on entry.
                    out_d   = res_nx;
                    ovf_d   = ovf_nx;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and scratch registers; reset discards any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd_out   = out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Self-checking bench for bin2bcd_converter: vector table, random
// conversions against an arithmetic reference, backpressure and reset cases.
module tb_bin2bcd_converter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] bin_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] bcd_out;
    logic        ovf;

    int vectors;
    int errors;
    int cyc;
    int last_accept;

`ifdef BIN2BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    bin2bcd_converter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by plain division
    function automatic logic [15:0] ref_bcd(input int v);
        int m;
        if (SAT && v > 9999) return 16'h9999;
        m = v % 10000;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic bit digits_ok(input logic [15:0] b);
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Full handshake with out_ready high; checks latency, result, II, return to IDLE
    task automatic run_one(input logic [13:0] v, input logic [15:0] exp_b,
                           input logic exp_o, input string tag, input bit b2b);
        int n;
        int acc;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_rdy"}, in_ready, 1);
        in_valid = 1'b1;
        bin_in   = v;
        @(posedge clk); #1;
        acc = cyc;
        in_valid = 1'b0;
        bin_in   = 14'($urandom);
        if (b2b && last_accept >= 0) check({tag, "_ii"}, acc - last_accept, 16);
        last_accept = acc;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_lat"}, n, 14);
        check({tag, "_bcd"}, bcd_out, exp_b);
        check({tag, "_ovf"}, ovf, exp_o);
        if (!exp_o) check({tag, "_dig"}, digits_ok(bcd_out), 1);
        @(posedge clk); #1;
        check({tag, "_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        vectors     = 0;
        errors      = 0;
        last_accept = -1;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        bin_in      = '0;
        out_ready   = 1'b1;

        tbl[0]  = '{14'd1234,  16'h1234, 1'b0};
        tbl[1]  = '{14'd0,     16'h0000, 1'b0};
        tbl[2]  = '{14'd9999,  16'h9999, 1'b0};
        tbl[3]  = '{14'd16383, SAT ? 16'h9999 : 16'h6383, 1'b1};
        tbl[4]  = '{14'd10000, SAT ? 16'h9999 : 16'h0000, 1'b1};
        tbl[5]  = '{14'd42,    16'h0042, 1'b0};
        tbl[6]  = '{14'd5,     16'h0005, 1'b0};
        tbl[7]  = '{14'd10,    16'h0010, 1'b0};
        tbl[8]  = '{14'd99,    16'h0099, 1'b0};
        tbl[9]  = '{14'd100,   16'h0100, 1'b0};
        tbl[10] = '{14'd1000,  16'h1000, 1'b0};
        tbl[11] = '{14'd9990,  16'h9990, 1'b0};
        tbl[12] = '{14'd12345, SAT ? 16'h9999 : 16'h2345, 1'b1};
        tbl[13] = '{14'd8765,  16'h8765, 1'b0};

        #23;
        check("rst_state", {in_ready, out_valid, ovf}, 3'b100);
        check("rst_bcd", bcd_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_one(tbl[i].bin, tbl[i].bcd, tbl[i].ovf, $sformatf("tbl%0d", i), 1'b1);
        end

        for (int i = 0; i < 300; i++) begin
            int v;
            v = (i < 40) ? i : ((i % 3 == 0) ? int'($urandom_range(16383, 10000))
                                             : int'($urandom_range(9999, 0)));
            run_one(14'(v), ref_bcd(v), v > 9999, $sformatf("rnd%0d", v), 1'b1);
        end

        // Backpressure: result held, new input ignored
        out_ready = 1'b0;
        in_valid  = 1'b1;
        bin_in    = 14'd42;
        @(posedge clk); #1;
        bin_in = 14'd7;
        for (int n = 0; n < 40 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 20; k++) begin
            check("bp_hold", {out_valid, in_ready, ovf, bcd_out}, {3'b100, 16'h0042});
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {in_ready, out_valid}, 2'b10);
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_ghost", {in_ready, out_valid}, 2'b10);

        // Reset mid-SHIFT
        in_valid = 1'b1;
        bin_in   = 14'd5000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", {in_ready, out_valid, ovf}, 3'b100);
        check("rst_mid_bcd", bcd_out, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_discard", {in_ready, out_valid}, 2'b10);
        last_accept = -1;
        run_one(14'd77, 16'h0077, 1'b0, "after_rst", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
